pipeline_sequencer: RTL and testbench

Central stall/flush/halt sequencer for the five-stage 16-bit pipeline. Combines the load-use stall from hazard detection, ID-stage branch redirects, instruction- and data-memory busy signals, and HLT decode. From these it drives every pipeline-register write enable and flush, plus the PC write enable. It also owns the halt drain state machine that retires in-flight instructions before asserting `halted`.

---
 rtl/pipeline_sequencer_if.sv | 33 +++
 rtl/pipeline_sequencer.sv | 147 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
// Pipeline control bundle between the hazard/decode/memory side and the
// stall/flush/halt sequencer.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             hazard_stall;
  logic             branch_taken;
  logic             halt_dec;
  logic             imem_busy;
  logic             dmem_busy;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_we;
  logic             id_ex_flush;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output hazard_stall, branch_taken, halt_dec, imem_busy, dmem_busy,
    input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
           ex_mem_we, mem_wb_we, halted, stall_cycles, flush_count
  );

  modport slave (
    input  hazard_stall, branch_taken, halt_dec, imem_busy, dmem_busy,
    output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
           ex_mem_we, mem_wb_we, halted, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Stall/flush/halt sequencer for the five-stage pipeline with halt drain FSM.
// SEQ_PERF_CNT_EN enables the saturating stall/flush performance counters.
//
// state   | meaning
// S_RUN   | normal issue; stall/flush/redirect priority decode
// S_DRAIN | HLT past ID, retiring in-flight instructions
// S_HALT  | pipeline empty, all registers frozen until rst
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_sequencer_if.slave  seq
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
  logic ex_mem_we, mem_wb_we, halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_we    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_we   = 1'b0;
    mem_wb_we   = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (seq.dmem_busy) begin
            // global freeze: every register holds
          end else if (seq.hazard_stall) begin
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
          end else if (seq.halt_dec) begin
            if_id_flush = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            state_d     = S_DRAIN;
            cnt_d       = CW'(DRAIN_CYCLES);
          end else if (seq.branch_taken) begin
            // redirect wins over a busy fetch: the pending fetch is discarded
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
          end else if (seq.imem_busy) begin
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
          end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
          end
        end
        S_DRAIN: begin
          if (!seq.dmem_busy) begin
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            if (cnt_q <= CW'(1)) begin
              state_d = S_HALT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  logic [CNT_W-1:0] stall_cnt, flush_cnt;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_q == S_RUN && !pc_we && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (if_id_flush && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign seq.pc_we        = pc_we;
  assign seq.if_id_we     = if_id_we;
  assign seq.if_id_flush  = if_id_flush;
  assign seq.id_ex_we     = id_ex_we;
  assign seq.id_ex_flush  = id_ex_flush;
  assign seq.ex_mem_we    = ex_mem_we;
  assign seq.mem_wb_we    = mem_wb_we;
  assign seq.halted       = halted;
  assign seq.stall_cycles = stall_cnt;
  assign seq.flush_count  = flush_cnt;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: expected control vectors are queued
// as stimulus is applied and compared at the following falling edge.
module tb_pipeline_sequencer;
  localparam int CNT_W = 16;

  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we, halted}
  localparam logic [7:0] V_RUN    = 8'b1101_0110;
  localparam logic [7:0] V_FREEZE = 8'b0000_0000;
  localparam logic [7:0] V_STALL  = 8'b0001_1110;
  localparam logic [7:0] V_HLTDEC = 8'b0011_0110;
  localparam logic [7:0] V_BRANCH = 8'b1111_0110;
  localparam logic [7:0] V_DRAIN  = 8'b0001_1110;
  localparam logic [7:0] V_HALTED = 8'b0000_0001;
  localparam logic [7:0] V_RESET  = 8'b0010_1000;

  // stimulus bits {rst, hazard_stall, branch_taken, halt_dec, imem_busy, dmem_busy}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_RST  = 6'b100000;
  localparam logic [5:0] I_HS   = 6'b010000;
  localparam logic [5:0] I_BT   = 6'b001000;
  localparam logic [5:0] I_HD   = 6'b000100;
  localparam logic [5:0] I_IB   = 6'b000010;
  localparam logic [5:0] I_DB   = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;
  logic [7:0] sb[$];
  logic [7:0] got, want;

  pipeline_sequencer_if #(.CNT_W(CNT_W)) sif ();

  pipeline_sequencer #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .seq (sif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {sif.pc_we, sif.if_id_we, sif.if_id_flush, sif.id_ex_we,
            sif.id_ex_flush, sif.ex_mem_we, sif.mem_wb_we, sif.halted};
  endfunction

  task automatic drive(input logic [5:0] in, input logic [7:0] exp);
    rst              = in[5];
    sif.hazard_stall = in[4];
    sif.branch_taken = in[3];
    sif.halt_dec     = in[2];
    sif.imem_busy    = in[1];
    sif.dmem_busy    = in[0];
    sb.push_back(exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(I_RST, V_RESET);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL reset[%0d] got %b want %b", i, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_run();
    for (int i = 0; i < 10; i++) begin
      drive(I_NONE, V_RUN);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL run[%0d] got %b want %b", i, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_hazard_branch();
    logic [5:0] ins [5] = '{I_HS | I_BT, I_BT, I_IB | I_BT, I_IB, I_NONE};
    logic [7:0] exps[5] = '{V_STALL, V_BRANCH, V_BRANCH, V_STALL, V_RUN};
    for (int i = 0; i < 5; i++) begin
      drive(ins[i], exps[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL hazard_branch[%0d] got %b want %b", i, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_dmem_freeze();
    logic [5:0] ins [5] = '{I_DB | I_HS, I_DB | I_HS, I_DB | I_HS, I_HS, I_NONE};
    logic [7:0] exps[5] = '{V_FREEZE, V_FREEZE, V_FREEZE, V_STALL, V_RUN};
    for (int i = 0; i < 5; i++) begin
      drive(ins[i], exps[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL dmem_freeze[%0d] got %b want %b", i, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_halt();
    logic [5:0] ins [7] = '{I_HD, I_BT, I_DB, I_NONE, I_NONE, I_NONE, I_BT | I_HD | I_HS};
    logic [7:0] exps[7] = '{V_HLTDEC, V_DRAIN, V_FREEZE, V_DRAIN, V_DRAIN, V_HALTED, V_HALTED};
    for (int i = 0; i < 7; i++) begin
      drive(ins[i], exps[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL halt[cycle %0d] got %b want %b", i, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [5:0] ins [9] = '{I_RST, I_HD, I_NONE, I_RST, I_NONE, I_NONE, I_NONE, I_NONE, I_NONE};
    logic [7:0] exps[9] = '{V_RESET, V_HLTDEC, V_DRAIN, V_RESET, V_RUN, V_RUN, V_RUN, V_RUN, V_RUN};
    for (int i = 0; i < 9; i++) begin
      drive(ins[i], exps[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL reset_mid_drain[%0d] got %b want %b", i, got, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_perf_counters();
    logic [5:0] ins [8] = '{I_RST, I_IB, I_BT, I_IB, I_IB, I_BT, I_IB, I_NONE};
    logic [7:0] exps[8] = '{V_RESET, V_STALL, V_BRANCH, V_STALL, V_STALL, V_BRANCH, V_STALL, V_RUN};
    logic [CNT_W-1:0] exp_stall, exp_flush;
`ifdef SEQ_PERF_CNT_EN
    exp_stall = CNT_W'(4);
    exp_flush = CNT_W'(2);
`else
    exp_stall = '0;
    exp_flush = '0;
`endif
    for (int i = 0; i < 8; i++) begin
      drive(ins[i], exps[i]);
      @(negedge clk);
      got = outs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL perf_seq[%0d] got %b want %b", i, got, want);
      end
      if (i == 7) begin
        checks++;
        if (sif.stall_cycles !== exp_stall) begin
          fails++;
          $display("FAIL stall_cycles got %0d want %0d", sif.stall_cycles, exp_stall);
        end
        checks++;
        if (sif.flush_count !== exp_flush) begin
          fails++;
          $display("FAIL flush_count got %0d want %0d", sif.flush_count, exp_flush);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    sif.hazard_stall = 1'b0;
    sif.branch_taken = 1'b0;
    sif.halt_dec     = 1'b0;
    sif.imem_busy    = 1'b0;
    sif.dmem_busy    = 1'b0;
    next_cycle();
    test_reset();
    test_run();
    test_hazard_branch();
    test_dmem_freeze();
    test_halt();
    test_reset_mid_drain();
    test_perf_counters();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d leftover want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
